// File: rtl/audio_pkg.sv
// Shared types and constants for the melody playback path.
// Provides the FSM state enum and the note-code to half-period table.
package audio_pkg;

  localparam int SAMPLE_W    = 24;
  localparam int NOTE_W      = 6;
  localparam int SAMPLE_RATE = 48000;
  localparam int HP_W        = 9;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  // round(SAMPLE_RATE / (2 * 440 * 2^((code-34)/12)))
  // Entry 0 is a rest; 1 keeps the phase logic well defined.
  localparam logic [HP_W-1:0] HALF_PERIOD [0:63] = '{
    9'd1,   9'd367, 9'd346, 9'd327,
    9'd309, 9'd291, 9'd275, 9'd259,
    9'd245, 9'd231, 9'd218, 9'd206,
    9'd194, 9'd183, 9'd173, 9'd163,
    9'd154, 9'd146, 9'd137, 9'd130,
    9'd122, 9'd116, 9'd109, 9'd103,
    9'd97,  9'd92,  9'd87,  9'd82,
    9'd77,  9'd73,  9'd69,  9'd65,
    9'd61,  9'd58,  9'd55,  9'd51,
    9'd49,  9'd46,  9'd43,  9'd41,
    9'd39,  9'd36,  9'd34,  9'd32,
    9'd31,  9'd29,  9'd27,  9'd26,
    9'd24,  9'd23,  9'd22,  9'd20,
    9'd19,  9'd18,  9'd17,  9'd16,
    9'd15,  9'd14,  9'd14,  9'd13,
    9'd12,  9'd11,  9'd11,  9'd10
  };

  function automatic logic [HP_W-1:0] half_period(
    input logic [NOTE_W-1:0] code
  );
    return HALF_PERIOD[code];
  endfunction

endpackage

// File: rtl/decoder_audio_playback_tone.sv
// Square-wave tone generator: phase counter plus polarity.
// Ports: clk, reset, advance (sample accepted), restart (phase 0,
// polarity +), code (note code), sample (signed 24-bit output).
module square_tone_gen
  import audio_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] AMPLITUDE = 24'h100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic                restart,
  input  logic [NOTE_W-1:0]   code,
  output logic [SAMPLE_W-1:0] sample
);

  logic [HP_W-1:0] r_phase;
  logic            r_neg;
  logic [HP_W-1:0] w_hp;
  logic            w_wrap;

  assign w_hp   = half_period(code);
  assign w_wrap = (r_phase == w_hp - 1'b1);

  // restart wins over advance so a note boundary
  // always starts the next note at phase 0, polarity +
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_phase <= '0;
      r_neg   <= 1'b0;
    end else if (advance) begin
      if (w_wrap) begin
        r_phase <= '0;
        r_neg   <= ~r_neg;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  always_comb begin
    sample = AMPLITUDE;
    if (code == '0) begin
      sample = '0;
    end else if (r_neg) begin
      sample = -AMPLITUDE;
    end
  end

endmodule

// File: rtl/decoder_audio_playback.sv
// Melody sequencer: note RAM -> square-wave samples -> codec FIFO.
// Ports: clk, reset (sync, active high), write_en (play level),
// note_RAM (note codes, slot 0 first), i_note (notes to play),
// write_ready (codec can accept), write / write_data (sample out).
module decoder_audio_playback
  import audio_pkg::*;
#(
  parameter int                  NUM_SLOTS        = 40,
  parameter int                  SAMPLES_PER_NOTE = 12000,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE        = 24'h100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic [NOTE_W-1:0]   note_RAM [NUM_SLOTS-1:0],
  input  logic [NOTE_W-1:0]   i_note,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] write_data
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  // one extra bit so the count can hold NUM_SLOTS itself
  localparam int N_W   = IDX_W + 1;
  localparam int CNT_W = $clog2(SAMPLES_PER_NOTE);

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(SAMPLES_PER_NOTE - 1);

  state_t r_state;
  state_t w_next;

  logic [N_W-1:0]      r_n;
  logic [N_W-1:0]      r_idx;
  logic [CNT_W-1:0]    r_cnt;

  logic [N_W-1:0]      w_n_clamp;
  logic [NOTE_W-1:0]   w_code;
  logic                w_accept;
  logic                w_last;
  logic                w_restart;
  logic [SAMPLE_W-1:0] w_sample;

  assign w_n_clamp = (int'(i_note) > NUM_SLOTS)
                   ? N_W'(NUM_SLOTS)
                   : N_W'(i_note);

  assign w_code   = note_RAM[r_idx[IDX_W-1:0]];
  assign w_accept = (r_state == PLAY) && write_ready;
  assign w_last   = (r_cnt == LAST_CNT);

  // outside PLAY the tone is held at phase 0, polarity +,
  // so every (re)start of playback begins positive
  assign w_restart = (r_state != PLAY)
                   || (w_accept && w_last);

  square_tone_gen #(
    .AMPLITUDE (AMPLITUDE)
  ) u_tone (
    .clk     (clk),
    .reset   (reset),
    .advance (w_accept),
    .restart (w_restart),
    .code    (w_code),
    .sample  (w_sample)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (write_en) begin
            r_n   <= w_n_clamp;
            r_idx <= '0;
            r_cnt <= '0;
          end
        end
        PLAY: begin
          if (w_accept) begin
            if (w_last) begin
              r_cnt <= '0;
              r_idx <= r_idx + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    write      = 1'b0;
    write_data = '0;
    case (r_state)
      IDLE: begin
        if (write_en) begin
          w_next = (w_n_clamp == '0) ? DONE : PLAY;
        end
      end
      PLAY: begin
        write      = write_ready;
        write_data = w_sample;
        if (!write_en) begin
          w_next = IDLE;
        end else if (w_accept && w_last
                     && (r_idx + 1'b1 == r_n)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (!write_en) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decoder_audio_playback.sv
// Scoreboard bench for decoder_audio_playback.
// Two instances: short notes (8 samples) and pitch notes (220).
module tb_decoder_audio_playback;

  localparam int          NS   = 40;
  localparam logic [23:0] AMP  = 24'h100000;
  localparam logic [23:0] NAMP = 24'hF00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wen_a, rdy_a, wr_a;
  logic        wen_b, rdy_b, wr_b;
  logic [5:0]  ram_a [NS-1:0];
  logic [5:0]  ram_b [NS-1:0];
  logic [5:0]  in_a, in_b;
  logic [23:0] wd_a, wd_b;

  bit gap_a, lvl_a, lvl_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int base;

  logic [23:0] q_a [$];
  logic [23:0] q_b [$];
  logic [23:0] e_a, e_b;

  decoder_audio_playback #(
    .NUM_SLOTS (NS), .SAMPLES_PER_NOTE (8), .AMPLITUDE (AMP)
  ) u_a (
    .clk (clk), .reset (reset), .write_en (wen_a),
    .note_RAM (ram_a), .i_note (in_a),
    .write_ready (rdy_a), .write (wr_a), .write_data (wd_a)
  );

  decoder_audio_playback #(
    .NUM_SLOTS (NS), .SAMPLES_PER_NOTE (220), .AMPLITUDE (AMP)
  ) u_b (
    .clk (clk), .reset (reset), .write_en (wen_b),
    .note_RAM (ram_b), .i_note (in_b),
    .write_ready (rdy_b), .write (wr_b), .write_data (wd_b)
  );

  // ready generator runs after the stimulus tasks in each cycle
  initial begin
    int ph;
    ph = 0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph++;
      rdy_a = gap_a ? (ph % 4 == 0) : lvl_a;
      rdy_b = lvl_b;
    end
  end

  always @(negedge clk) begin
    if (wr_a === 1'b1) begin
      cnt_a++;
      n_cmp++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_extra_write #%0d: got %h, required no write",
                 cnt_a, wd_a);
      end else begin
        e_a = q_a.pop_front();
        if (wd_a !== e_a) begin
          n_bad++;
          $display("FAIL a_sample #%0d: got %h, required %h",
                   cnt_a, wd_a, e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wr_b === 1'b1) begin
      cnt_b++;
      n_cmp++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_extra_write #%0d: got %h, required no write",
                 cnt_b, wd_b);
      end else begin
        e_b = q_b.pop_front();
        if (wd_b !== e_b) begin
          n_bad++;
          $display("FAIL b_sample #%0d: got %h, required %h",
                   cnt_b, wd_b, e_b);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hand-computed half periods: code 34 = 440 Hz -> 55,
  // code 60 -> 12. Every code has half period >= 10, so an
  // 8-sample note never changes sign.
  function automatic int hp_hand(input logic [5:0] code);
    if (code == 6'd34) return 55;
    if (code == 6'd60) return 12;
    return 64;
  endfunction

  function automatic logic [23:0] model(input logic [5:0] code,
                                        input int j);
    if (code == 6'd0) return 24'h0;
    return (((j / hp_hand(code)) % 2) == 1) ? NAMP : AMP;
  endfunction

  task automatic push_a(input logic [5:0] code);
    for (int j = 0; j < 8; j++) q_a.push_back(model(code, j));
  endtask

  task automatic push_b(input logic [5:0] code, input int n);
    for (int j = 0; j < n; j++) q_b.push_back(model(code, j));
  endtask

  task automatic wait_cnt(input bit on_b, input int target,
                          input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if ((on_b ? cnt_b : cnt_a) >= target) break;
    end
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    wen_a = 1'b1;
    wen_b = 1'b1;
    in_a  = '0;
    in_b  = '0;
    gap_a = 1'b0;
    lvl_a = 1'b1;
    lvl_b = 1'b1;
    foreach (ram_a[k]) ram_a[k] = '0;
    foreach (ram_b[k]) ram_b[k] = '0;

    step(2);
    chk("rst_write_a", 32'(wr_a), 0);
    chk("rst_data_a", 32'(wd_a), 0);
    chk("rst_write_b", 32'(wr_b), 0);
    chk("rst_data_b", 32'(wd_b), 0);
    reset = 1'b0;
    wen_a = 1'b0;
    wen_b = 1'b0;
    step(2);
    chk("idle_write_a", 32'(wr_a), 0);

    // melody {0,1,2,3,4}, ready 1 cycle in 4
    for (int k = 0; k < 5; k++) begin
      ram_a[k] = 6'(k);
      push_a(6'(k));
    end
    in_a  = 6'd5;
    gap_a = 1'b1;
    base  = cnt_a;
    wen_a = 1'b1;
    wait_cnt(1'b0, base + 40, 400);
    step(50);
    chk("a_melody_count", 32'(cnt_a - base), 40);
    chk("a_done_write", 32'(wr_a), 0);
    chk("a_done_data", 32'(wd_a), 0);
    chk("a_melody_queue", 32'(q_a.size()), 0);
    wen_a = 1'b0;
    step(2);

    // zero notes: straight to DONE
    in_a  = 6'd0;
    base  = cnt_a;
    wen_a = 1'b1;
    step(20);
    chk("a_zero_notes", 32'(cnt_a - base), 0);
    wen_a = 1'b0;
    step(2);

    // i_note above NUM_SLOTS clamps to 40 notes
    gap_a = 1'b0;
    for (int k = 0; k < NS; k++) begin
      ram_a[k] = 6'((k * 7) % 64);
      push_a(6'((k * 7) % 64));
    end
    in_a  = 6'd50;
    base  = cnt_a;
    wen_a = 1'b1;
    wait_cnt(1'b0, base + 320, 1000);
    step(20);
    chk("a_clamp_count", 32'(cnt_a - base), 320);
    chk("a_clamp_queue", 32'(q_a.size()), 0);
    wen_a = 1'b0;
    step(2);

    // pitch: code 34, stall 100 cycles just before the flip
    ram_b[0] = 6'd34;
    in_b  = 6'd1;
    push_b(6'd34, 220);
    base  = cnt_b;
    wen_b = 1'b1;
    wait_cnt(1'b1, base + 54, 300);
    lvl_b = 1'b0;
    c0    = cnt_b;
    step(50);
    chk("b_stall_write", 32'(wr_b), 0);
    step(50);
    chk("b_stall_nowrite", 32'(cnt_b - c0), 0);
    lvl_b = 1'b1;
    wait_cnt(1'b1, base + 220, 400);
    step(20);
    chk("b_pitch_count", 32'(cnt_b - base), 220);
    chk("b_pitch_queue", 32'(q_b.size()), 0);
    wen_b = 1'b0;
    step(2);

    // abort mid-note while polarity is negative
    ram_b[0] = 6'd60;
    ram_b[1] = 6'd34;
    ram_b[2] = 6'd60;
    in_b  = 6'd3;
    push_b(6'd60, 15);
    base  = cnt_b;
    wen_b = 1'b1;
    wait_cnt(1'b1, base + 14, 100);
    wen_b = 1'b0;
    step(1);
    chk("b_abort_write", 32'(wr_b), 0);
    step(5);
    chk("b_abort_count", 32'(cnt_b - base), 15);
    chk("b_abort_queue", 32'(q_b.size()), 0);

    // restart from slot 0, positive, then hold in DONE
    push_b(6'd60, 220);
    push_b(6'd34, 220);
    push_b(6'd60, 220);
    base  = cnt_b;
    wen_b = 1'b1;
    wait_cnt(1'b1, base + 660, 1000);
    step(40);
    chk("b_restart_count", 32'(cnt_b - base), 660);
    chk("b_done_write", 32'(wr_b), 0);
    chk("b_done_data", 32'(wd_b), 0);
    chk("b_restart_queue", 32'(q_b.size()), 0);
    wen_b = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
